// File: rtl/bcd_lcd_sched_pkg.sv
// -----------------------------------------------------------------------------
// bcd_lcd_sched_pkg
// Shared definitions for the BCD-to-LCD character scheduler:
//   - state_t       : scheduler FSM states
//   - ASCII_*       : character codes sent to the LCD writer
//   - IDX_*         : char_idx values (which digit is on char_out)
//   - digit_to_ascii: maps one BCD digit plus a blank flag to an ASCII code
// -----------------------------------------------------------------------------
package bcd_lcd_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SEND_H = 3'd2,
        ST_SEND_T = 3'd3,
        ST_SEND_U = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;

    localparam logic [1:0] IDX_HUNDREDS = 2'd0;
    localparam logic [1:0] IDX_TENS     = 2'd1;
    localparam logic [1:0] IDX_UNITS    = 2'd2;

    // Blank wins over the range check: blanking is decided on the raw digit
    // by the caller, and a blanked digit is by definition zero.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit,
                                                  input logic       blank);
        logic [7:0] chr;
        if (blank) begin
            chr = ASCII_SPACE;
        end else if (digit > 4'd9) begin
            chr = ASCII_ERR;
        end else begin
            chr = ASCII_ZERO + {4'h0, digit};
        end
        return chr;
    endfunction

endpackage

// File: rtl/bcd_lcd_sched_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter_n
// Combinational round-robin pick: returns the first set request bit found
// searching upward from i_ptr, wrapping past N_REQ-1 back to 0.
// Ports:
//   i_req    : request vector
//   i_ptr    : highest-priority index for this pick (must be < N_REQ)
//   o_valid  : at least one request is set
//   o_idx    : index of the picked requester
//   o_onehot : one-hot form of o_idx (all zero when o_valid is low)
// -----------------------------------------------------------------------------
module rr_arbiter_n #(
    parameter int N_REQ = 2,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [SRC_W-1:0] o_idx,
    output logic [N_REQ-1:0] o_onehot
);

    // Rotating priority search; the first hit freezes the result.
    always_comb begin
        int  w_sum;
        int  w_k;
        logic w_hit;
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_sum    = 0;
        w_k      = 0;
        w_hit    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_sum       = int'(i_ptr) + i;
            w_k         = (w_sum >= N_REQ) ? (w_sum - N_REQ) : w_sum;
            w_hit       = !o_valid && i_req[w_k];
            o_onehot[w_k] = o_onehot[w_k] | w_hit;
            o_idx       = w_hit ? SRC_W'(w_k) : o_idx;
            o_valid     = o_valid | w_hit;
        end
    end

endmodule

// File: rtl/bcd_lcd_sched.sv
// -----------------------------------------------------------------------------
// bcd_lcd_sched
// Shares one external combinational 8-bit binary-to-BCD converter between
// N_REQ byte sources. A round-robin pick selects a requester, its byte is
// registered onto o_conv_bin, the returned digits are captured, and the value
// is streamed to the LCD writer as three ASCII characters (hundreds, tens,
// units) over a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_req, i_bin_in       : per-requester request and byte (k at [8k+7:8k])
//   o_gnt, o_done         : one-cycle accept / all-characters-delivered pulses
//   o_conv_bin            : byte presented to the shared converter
//   i_conv_hundreds/tens/units : converter digits
//   o_char_out/valid/idx/src, i_char_ready : character stream to LCD writer
//   o_busy                : high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module bcd_lcd_sched
    import bcd_lcd_sched_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int LEADING_BLANK = 1,
    parameter int SRC_W         = $clog2(N_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_bin_in,
    output logic [N_REQ-1:0]     o_gnt,
    output logic [N_REQ-1:0]     o_done,
    output logic [7:0]           o_conv_bin,
    input  logic [3:0]           i_conv_hundreds,
    input  logic [3:0]           i_conv_tens,
    input  logic [3:0]           i_conv_units,
    output logic [7:0]           o_char_out,
    output logic                 o_char_valid,
    input  logic                 i_char_ready,
    output logic [1:0]           o_char_idx,
    output logic [SRC_W-1:0]     o_char_src,
    output logic                 o_busy
);

    state_t             r_state;
    logic [SRC_W-1:0]   r_ptr;
    logic [SRC_W-1:0]   r_src;
    logic [3:0]         r_h;
    logic [3:0]         r_t;
    logic [3:0]         r_u;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_done;
    logic [7:0]         r_conv_bin;
    logic [7:0]         r_char_out;
    logic               r_char_valid;
    logic [1:0]         r_char_idx;
    logic [SRC_W-1:0]   r_char_src;
    logic               r_busy;

    logic               w_arb_valid;
    logic [SRC_W-1:0]   w_arb_idx;
    logic [N_REQ-1:0]   w_arb_onehot;
    logic [SRC_W-1:0]   w_next_ptr;
    logic [7:0]         w_bin_sel;
    logic [N_REQ-1:0]   w_src_onehot;
    logic               w_blank_en;
    logic               w_xfer;

    rr_arbiter_n #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_arb (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_valid  (w_arb_valid),
        .o_idx    (w_arb_idx),
        .o_onehot (w_arb_onehot)
    );

    assign w_bin_sel    = i_bin_in[8*w_arb_idx +: 8];
    assign w_next_ptr   = (w_arb_idx == SRC_W'(N_REQ-1)) ? '0 : (w_arb_idx + SRC_W'(1));
    assign w_src_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_src;
    assign w_blank_en   = (LEADING_BLANK != 0);
    assign w_xfer       = r_char_valid && i_char_ready;

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_src        <= '0;
            r_h          <= 4'd0;
            r_t          <= 4'd0;
            r_u          <= 4'd0;
            r_gnt        <= '0;
            r_done       <= '0;
            r_conv_bin   <= 8'd0;
            r_char_out   <= 8'd0;
            r_char_valid <= 1'b0;
            r_char_idx   <= 2'd0;
            r_char_src   <= '0;
            r_busy       <= 1'b0;
        end else begin
            // gnt and done are single-cycle pulses.
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_src      <= w_arb_idx;
                        r_conv_bin <= w_bin_sel;
                        r_ptr      <= w_next_ptr;
                        r_gnt      <= w_arb_onehot;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_busy     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Converter has settled from r_conv_bin during this cycle;
                    // the hundreds character is built straight from its output.
                    r_h          <= i_conv_hundreds;
                    r_t          <= i_conv_tens;
                    r_u          <= i_conv_units;
                    r_char_out   <= digit_to_ascii(i_conv_hundreds,
                                        w_blank_en && (i_conv_hundreds == 4'd0));
                    r_char_valid <= 1'b1;
                    r_char_idx   <= IDX_HUNDREDS;
                    r_char_src   <= r_src;
                    r_state      <= ST_SEND_H;
                end
                ST_SEND_H: begin
                    if (w_xfer) begin
                        r_char_out <= digit_to_ascii(r_t,
                                        w_blank_en && (r_h == 4'd0) && (r_t == 4'd0));
                        r_char_idx <= IDX_TENS;
                        r_state    <= ST_SEND_T;
                    end else begin
                        r_state    <= ST_SEND_H;
                    end
                end
                ST_SEND_T: begin
                    if (w_xfer) begin
                        // Units is never blanked so a value of zero shows '0'.
                        r_char_out <= digit_to_ascii(r_u, 1'b0);
                        r_char_idx <= IDX_UNITS;
                        r_state    <= ST_SEND_U;
                    end else begin
                        r_state    <= ST_SEND_T;
                    end
                end
                ST_SEND_U: begin
                    if (w_xfer) begin
                        r_char_valid <= 1'b0;
                        r_char_out   <= 8'd0;
                        r_char_idx   <= 2'd0;
                        r_done       <= w_src_onehot;
                        r_state      <= ST_DONE;
                    end else begin
                        r_state      <= ST_SEND_U;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_char_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_done       = r_done;
    assign o_conv_bin   = r_conv_bin;
    assign o_char_out   = r_char_out;
    assign o_char_valid = r_char_valid;
    assign o_char_idx   = r_char_idx;
    assign o_char_src   = r_char_src;
    assign o_busy       = r_busy;

endmodule

// File: doc/bcd_lcd_sched.md
Name: bcd_lcd_sched

Overview:
- Shares one combinational 8-bit binary-to-BCD converter between N_REQ byte sources, e.g. DHT11 humidity and temperature integer bytes.
- Arbitrates round-robin, drives the converter, and registers its three BCD digits.
- Streams the result to the LCD character writer as three ASCII characters over a valid/ready handshake.
- Sits between the sensor decode logic and the LCD command/data sequencer.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- LEADING_BLANK, 1, 1 = leading zeros of hundreds/tens sent as space 8'h20; 0 = sent as '0'.
- SRC_W, $clog2(N_REQ), width of char_src (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  N_REQ  per-requester conversion request; held until gnt.
- bin_in  in  8*N_REQ  requester k byte at bits [8k+7:8k].
- gnt  out  N_REQ  one-cycle pulse: request k accepted.
- done  out  N_REQ  one-cycle pulse: all 3 chars of k delivered.
- conv_bin  out  8  registered byte to shared converter.
- conv_hundreds  in  4  converter hundreds digit.
- conv_tens  in  4  converter tens digit.
- conv_units  in  4  converter units digit.
- char_out  out  8  ASCII character.
- char_valid  out  1  char_out valid.
- char_ready  in  1  LCD writer accepts char_out.
- char_idx  out  2  0 = hundreds, 1 = tens, 2 = units.
- char_src  out  SRC_W  requester owning current char.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr = 0. Reset mid-operation abandons the transfer (no done) and returns to IDLE next cycle.
- States: IDLE, LOAD, SEND_H, SEND_T, SEND_U, DONE.
- IDLE: on an edge where any req bit is high, pick the first set bit searching from rr_ptr upward with wrap. Latch its index into src and bin_in slice into conv_bin. Go to LOAD. rr_ptr <= (granted+1) mod N_REQ.
- LOAD: gnt[src] = 1 for this single cycle. The converter settles combinationally from conv_bin. At the end of LOAD, register the three digits into h/t/u. Go to SEND_H.
- SEND_x: char_valid = 1; char_idx = 0/1/2; char_src = src. char_out = 8'h30 + digit.
- Transfer occurs on an edge with char_valid && char_ready, then advance H->T->U->DONE.
- While char_ready is low: char_out, char_idx and char_src hold stable; no state change.
- Blanking (LEADING_BLANK=1): hundreds blank if h==0; tens blank if h==0 && t==0; units never blank (0 -> '0').
- Digit > 9 (corrupt converter output) -> char '?' 8'h3F; blanking is evaluated on raw value.
- DONE: done[src] = 1 for one cycle; char_valid = 0; go to IDLE.
- Throughput with char_ready tied high: req sampled at edge 0; gnt in cycle 1; chars in cycles 2, 3, 4; done in cycle 5; next grant sampled at end of cycle 6.
- Requests arriving while busy stay pending. Requesters must hold req until gnt. Deasserting req before gnt cancels the request with no gnt.
- conv_bin holds its value until the next grant.

Decomposition:
- Shared package lcd_pkg: state enum, ASCII_ZERO = 8'h30, ASCII_SPACE = 8'h20, ASCII_ERR = 8'h3F, char-index constants.
- Sub-module rr_arbiter_n (req, ptr -> one-hot/indexed grant) is natural and reusable.
- The converter stays external and shared.

Test Plan:
- Test 1, single request: rst_n low 2 cycles then high; req[0]=1, bin 8'd123, ready=1, behavioural converter -> gnt[0] cycle 1; chars 0x31, 0x32, 0x33 with idx 0/1/2, src 0; done[0] cycle 5.
- Test 2, value sweep with LEADING_BLANK=1:
  - 0 -> 0x20, 0x20, 0x30
  - 7 -> 0x20, 0x20, 0x37
  - 40 -> 0x20, 0x34, 0x30
  - 255 -> 0x32, 0x35, 0x35
  - With LEADING_BLANK=0, 7 -> 0x30, 0x30, 0x37.
- Test 3, arbitration: req=2'b11 held after reset -> requester 0 served first, then 1. Reassert both -> 0 again (pointer wrapped). Verify no gnt while busy.
- Test 4, backpressure: char_ready low 3 cycles during SEND_T of 8'd58 -> char_out stays 0x35 and valid stays high; sequence 0x20, 0x35, 0x38; done delayed 3 cycles.
- Test 5, reset during SEND_T -> next cycle all outputs 0, no done pulse. A following req[1] with 8'd99 produces 0x20, 0x39, 0x39 with src 1.
- Test 6, stub converter returning tens = 4'hA -> second char 0x3F; hundreds/units unaffected.
